// File: rtl/wb16_cmd_master.sv
// Command-stream driven 16-bit Wishbone classic master: queued register accesses,
// one single-beat bus cycle per command, one response (data or timeout) per command.
module wb16_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [2:0]                    cmd_adr,
    input  logic [15:0]                   cmd_dat,
    input  logic [1:0]                    cmd_sel,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [15:0]                   rsp_dat,
    output logic                          rsp_we,
    output logic                          rsp_err,
    output logic [2:0]                    wbm_adr_o,
    output logic [15:0]                   wbm_dat_o,
    input  logic [15:0]                   wbm_dat_i,
    output logic                          wbm_we_o,
    output logic [1:0]                    wbm_sel_o,
    output logic                          wbm_stb_o,
    input  logic                          wbm_ack_i,
    output logic                          wbm_cyc_o,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int ENT_W = 22;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        adr_q, adr_d;
    logic [15:0]       dat_o_q, dat_o_d;
    logic              we_q, we_d;
    logic [1:0]        sel_q, sel_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_dat_q, rsp_dat_d;
    logic              rsp_we_q, rsp_we_d;
    logic              rsp_err_q, rsp_err_d;

    logic              push, pop;
    logic [ENT_W-1:0]  head;

    // Entry layout: {we, adr[2:0], sel[1:0], dat[15:0]}
    assign push = cmd_valid && cmd_ready_q;
    assign pop  = (state_q == S_IDLE) && (level_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_we, cmd_adr, cmd_sel, cmd_dat};
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_o_d     = dat_o_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    we_d     = head[21];
                    adr_d    = head[20:18];
                    sel_d    = head[17:16];
                    dat_o_d  = head[21] ? head[15:0] : 16'h0000;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_BUS;
                end
            end
            S_BUS: begin
                // Ack has priority over a timeout expiring on the same edge.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? 16'h0000 : wbm_dat_i;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_we_d    = we_q;
                        rsp_err_d   = 1'b1;
                        rsp_dat_d   = 16'h0000;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        cmd_ready_d = (level_d != LVL_FULL);
        busy_d      = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_o_q     <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_o_q     <= dat_o_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign cmd_level = level_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_o_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/wb16_cmd_master.md
Name: wb16_cmd_master

Overview:
- Synthesizable 16-bit Wishbone classic master; sits directly upstream of the 16-bit Wishbone-slave I2C master and drives its host bus.
- Accepts register-access commands on a valid/ready stream and buffers them in a small FIFO.
- Executes each command as one single Wishbone cycle.
- Returns one response per command (read data or timeout error) on a valid/ready stream. Lets a sequencer or bench script I2C register traffic without hand-driving bus phases.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT, 255: max cycles with stb high and no ack before abort; 0 disables timeout.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  3  register address
- cmd_dat  in  16  write data
- cmd_sel  in  2  byte selects
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  16  read data; 0 for writes and errors
- rsp_we  out  1  echo of command cmd_we
- rsp_err  out  1  1 = timed out
- wbm_adr_o  out  3  Wishbone address
- wbm_dat_o  out  16  Wishbone write data
- wbm_dat_i  in  16  Wishbone read data
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  2  byte selects
- wbm_stb_o  out  1  strobe
- wbm_ack_i  in  1  acknowledge
- wbm_cyc_o  out  1  cycle
- busy  out  1  FSM not IDLE, or FIFO non-empty
- cmd_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs registered and reset to 0, except cmd_ready = 1.
- Reset effects: FIFO emptied, FSM to IDLE, timeout counter 0.
- Reset mid-bus-cycle: cyc/stb low immediately after the reset edge; the pending command and response are discarded.

FIFO:
- Push on cmd_valid && cmd_ready. Pop only in IDLE.
- cmd_ready = !full, registered. When full, no push is accepted even in a cycle that pops.
- Commands execute strictly in acceptance order.
- cmd_level tracks occupancy exactly, including simultaneous push and pop (level unchanged).

FSM states: IDLE, BUS, RESP.
- IDLE:
  - If FIFO non-empty: pop the head, load wbm_adr_o / wbm_dat_o / wbm_we_o / wbm_sel_o, set cyc = stb = 1, counter = 0, go to BUS.
  - For reads, wbm_dat_o is driven 0.
- BUS:
  - cyc/stb held high with address, data and control stable.
  - Ack sampled high on an edge: capture wbm_dat_i if read (0 if write), rsp_err = 0, drop cyc/stb, set rsp_valid, go to RESP.
  - No ack: counter increments. If TIMEOUT != 0 and counter reaches TIMEOUT: drop cyc/stb, rsp_dat = 0, rsp_err = 1, set rsp_valid, go to RESP.
- RESP:
  - rsp_valid, rsp_dat, rsp_we, rsp_err held stable until rsp_valid && rsp_ready on an edge.
  - Then rsp_valid = 0 and go to IDLE.

Timing:
- Command accepted on edge E into an empty FIFO with FSM in IDLE: cyc/stb high after edge E+1.
- Ack on edge A: cyc/stb low and rsp_valid high after A; minimum bus cycle is one clock.
- Response handshake on edge R: next cyc/stb high at earliest after R+1.
- Consecutive bus cycles always have at least 2 idle clocks between them.

Boundaries:
- wbm_ack_i outside BUS is ignored.
- Ack on the same edge as the timeout terminal count: ack wins, rsp_err = 0.
- Capacity with rsp_ready held low: FIFO_DEPTH + 1 commands accepted (1 in FSM, FIFO_DEPTH queued).
- busy = 0 only when IDLE and the FIFO is empty.

Test Plan:
1. Write cmd adr=3, dat=0x00A5, sel=2'b11; slave acks 1 cycle after stb -> bus shows adr 3, dat 0x00A5, we 1 for 2 clocks; response rsp_we=1, rsp_dat=0, rsp_err=0.
2. Read cmd adr=1; slave acks 2 cycles after stb with 0x1234 -> stb high 3 clocks; rsp_dat=0x1234, rsp_err=0; wbm_dat_o=0 during the cycle.
3. TIMEOUT=8, read adr=2, no ack -> stb high exactly 8 clocks then low; rsp_err=1, rsp_dat=0. A following command executes normally.
4. rsp_ready held low, immediate acks, FIFO_DEPTH=4 -> 5 commands accepted, cmd_ready low on the 6th, cmd_level=4. Releasing rsp_ready drains responses in command order.
5. Three back-to-back commands (write 0x0011 adr0, read adr1 = 0xBEEF, write 0x0022 adr2), rsp_ready=1 -> bus order and response order match acceptance; at least 2 idle clocks between cycles.
6. rst asserted while in BUS with stb high, FIFO holding 2 -> after that edge: cyc/stb=0, cmd_level=0, rsp_valid=0, cmd_ready=1. No stale response appears afterwards.
